// File: rtl/acc_writeback.sv
// rtl/acc_writeback.sv - accumulate MAC product terms per neuron and write saturated results
//
// Purpose: sums signed product terms for each neuron of a layer pass, rescales
// the sum from Q(2*FRAC_BITS) to Q(FRAC_BITS), clamps it to the destination
// width, and issues one write strobe per neuron followed by a done pulse.
//
// Optional build macro: ACC_WRITEBACK_RELU_EN (negative results written as 0).
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-low reset
//   start        in   one-cycle pulse that begins a pass (ignored while busy)
//   num_neurons  in   neurons in the pass, sampled on accepted start; 0 = 2**I_WIDTH
//   in_valid     in   in_data/in_last valid
//   in_ready     out  beat accepted this cycle when in_valid is also high
//   in_data      in   signed product term, 2*D_WIDTH bits
//   in_last      in   beat is the last term of the current neuron
//   w_en         out  destination write strobe
//   index_out    out  destination entry index
//   data_out     out  value to write
//   busy         out  pass in progress
//   done         out  one-cycle pulse at end of pass
module acc_writeback #(
  parameter int I_WIDTH   = 4,
  parameter int D_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [I_WIDTH:0]     num_neurons,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*D_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 w_en,
  output logic [I_WIDTH-1:0]   index_out,
  output logic [D_WIDTH-1:0]   data_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Full pass length when num_neurons is 0.
  localparam logic [I_WIDTH:0] EFF_MAX = {1'b1, {I_WIDTH{1'b0}}};

  // Clamp bounds expressed at accumulator width for signed comparison.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  state_t                        r_state;
  state_t                        w_next;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic        [I_WIDTH-1:0]     r_cnt;
  logic        [I_WIDTH:0]       r_eff;
  logic        [I_WIDTH-1:0]     r_index;
  logic        [D_WIDTH-1:0]     r_data;

  logic                          w_accept;
  logic                          w_final;
  logic        [I_WIDTH:0]       w_last_idx;
  logic signed [ACC_WIDTH-1:0]   w_term;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [ACC_WIDTH-1:0]   w_shift;
  logic        [D_WIDTH-1:0]     w_sat;
  logic        [D_WIDTH-1:0]     w_result;

  assign w_accept   = (r_state == ACCUM) && in_valid;
  assign w_last_idx = r_eff - 1'b1;
  assign w_final    = ({1'b0, r_cnt} == w_last_idx);

  // The sum including the current beat is rescaled directly, so the result
  // register is loaded on the same edge that accepts the last beat and is
  // already valid during the WRITE cycle.
  assign w_term  = {{(ACC_WIDTH-2*D_WIDTH){in_data[2*D_WIDTH-1]}}, in_data};
  assign w_sum   = r_acc + w_term;
  assign w_shift = w_sum >>> FRAC_BITS;

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[D_WIDTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[D_WIDTH-1:0];
    end else begin
      w_sat = w_shift[D_WIDTH-1:0];
    end
  end

`ifdef ACC_WRITEBACK_RELU_EN
  assign w_result = w_sat[D_WIDTH-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_en     = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && in_last) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        w_en   = 1'b1;
        w_next = w_final ? DONE : ACCUM;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_eff   <= '0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_eff <= (num_neurons == '0) ? EFF_MAX : num_neurons;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (in_last) begin
              r_index <= r_cnt;
              r_data  <= w_result;
            end
          end
        end
        WRITE: begin
          if (!w_final) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign index_out = r_index;
  assign data_out  = r_data;

endmodule

// File: tb/tb_acc_writeback.sv
// tb/tb_acc_writeback.sv - directed self-checking bench for acc_writeback
module tb_acc_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  num_neurons;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        w_en;
  logic [3:0]  index_out;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  acc_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_neurons (num_neurons),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .w_en        (w_en),
    .index_out   (index_out),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] n);
    start       = 1'b1;
    num_neurons = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_en, index_out, data_out, busy, done, in_ready} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: w_en=%0b idx=%0h data=%h busy=%0b done=%0b rdy=%0b, required all 0",
               w_en, index_out, data_out, busy, done, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_start(5'd1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_accum: busy=%0b in_ready=%0b, required 1 1", busy, in_ready);
    end
    send_beat(32'h0001_0000, 1'b0);
    checks++;
    if (w_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_early_write: w_en=%0b, required 0", w_en);
    end
    send_beat(32'h0000_8000, 1'b1);
    checks++;
    if (w_en !== 1'b1 || index_out !== 4'd0 || data_out !== 16'h0180 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_write: w_en=%0b idx=%0h data=%h rdy=%0b, required 1 0 0180 0",
               w_en, index_out, data_out, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || w_en !== 1'b0 || data_out !== 16'h0180 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%0b w_en=%0b data=%h rdy=%0b, required 1 0 0180 0",
               done, w_en, data_out, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%0b busy=%0b, required 0 0", done, busy);
    end
  endtask

  task automatic test_saturation;
    do_start(5'd1);
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b1);
    checks++;
    if (w_en !== 1'b1 || data_out !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos: w_en=%0b data=%h, required 1 7fff", w_en, data_out);
    end
    repeat (2) @(negedge clk);
    do_start(5'd1);
    send_beat(32'h8000_0000, 1'b1);
    checks++;
    if (w_en !== 1'b1 || data_out !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg: w_en=%0b data=%h, required 1 8000", w_en, data_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_negative;
    logic [15:0] exp_v;
`ifdef ACC_WRITEBACK_RELU_EN
    exp_v = 16'h0000;
`else
    exp_v = 16'hFF00;
`endif
    do_start(5'd1);
    send_beat(32'hFFFF_0000, 1'b1);
    checks++;
    if (w_en !== 1'b1 || data_out !== exp_v) begin
      errors++;
      $display("FAIL negative: w_en=%0b data=%h, required 1 %h", w_en, data_out, exp_v);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_pass;
    do_start(5'd0);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(32'(i) << 16, 1'b1);
      checks++;
      if (w_en !== 1'b1 || index_out !== 4'(i) || data_out !== (16'(i) << 8) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_write[%0d]: w_en=%0b idx=%0h data=%h rdy=%0b, required 1 %0h %h 0",
                 i, w_en, index_out, data_out, in_ready, i, 16'(i) << 8);
      end
      @(negedge clk);
      checks++;
      if (done !== (i == 15) || w_en !== 1'b0) begin
        errors++;
        $display("FAIL full_after[%0d]: done=%0b w_en=%0b, required %0b 0", i, done, w_en, i == 15);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_mid_reset;
    int wr;
    do_start(5'd8);
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h0001_0000, 1'b1);
    end
    send_beat(32'h0100_0000, 1'b0);
    send_beat(32'h0100_0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_en, index_out, data_out, busy, done, in_ready} !== 24'h0) begin
      errors++;
      $display("FAIL midreset_outputs: w_en=%0b idx=%0h data=%h busy=%0b done=%0b rdy=%0b, required all 0",
               w_en, index_out, data_out, busy, done, in_ready);
    end
    rst = 1'b1;
    wr = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_en) wr++;
    end
    checks++;
    if (wr != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_write: writes=%0d busy=%0b, required 0 0", wr, busy);
    end
    do_start(5'd1);
    send_beat(32'h0002_0000, 1'b1);
    checks++;
    if (w_en !== 1'b1 || index_out !== 4'd0 || data_out !== 16'h0200) begin
      errors++;
      $display("FAIL midreset_clean: w_en=%0b idx=%0h data=%h, required 1 0 0200",
               w_en, index_out, data_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    do_start(5'd3);
    send_beat(32'h0000_0100, 1'b1);
    @(negedge clk);
    start       = 1'b1;
    num_neurons = 5'd2;
    @(negedge clk);
    start = 1'b0;
    send_beat(32'h0000_0200, 1'b1);
    checks++;
    if (w_en !== 1'b1 || index_out !== 4'd1 || data_out !== 16'h0002) begin
      errors++;
      $display("FAIL ignore_idx1: w_en=%0b idx=%0h data=%h, required 1 1 0002", w_en, index_out, data_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_done: done=%0b rdy=%0b, required 0 1", done, in_ready);
    end
    send_beat(32'h0000_0300, 1'b1);
    checks++;
    if (w_en !== 1'b1 || index_out !== 4'd2 || data_out !== 16'h0003) begin
      errors++;
      $display("FAIL ignore_idx2: w_en=%0b idx=%0h data=%h, required 1 2 0003", w_en, index_out, data_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done=%0b, required 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    num_neurons = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_saturation;
    test_negative;
    test_full_pass;
    test_mid_reset;
    test_start_ignored;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
